// File: rtl/pool_engine_if.sv
// Frame-level handshake and flattened map buses between a pooling engine and its producer/consumer.
interface pool_engine_if #(
    parameter int IN_BITS  = 16*8*8*3,
    parameter int OUT_BITS = 16*4*4*3
);
    logic                clken;
    logic                start;
    logic                mode;
    logic [IN_BITS-1:0]  data_in;
    logic                busy;
    logic [OUT_BITS-1:0] result_out;
    logic                result_valid_out;

    modport master (output clken, start, mode, data_in,
                    input  busy, result_out, result_valid_out);
    modport slave  (input  clken, start, mode, data_in,
                    output busy, result_out, result_valid_out);
endinterface

// File: rtl/pool_engine.sv
// Sequential max/average pooling over a flattened multi-channel map, one window element per enabled cycle.
//   state   | meaning
//   S_IDLE  | waiting for start; result_out holds the last frame
//   S_ACC   | folding window element (kx,ky) into the accumulator
//   S_WRITE | storing the window result, stepping ox -> oy -> channel
module pool_engine #(
    parameter int BITWIDTH    = 16,
    parameter int DATAWIDTH   = 8,
    parameter int DATAHEIGHT  = 8,
    parameter int DATACHANNEL = 3,
    parameter int KWIDTH      = 2,
    parameter int KHEIGHT     = 2,
    parameter int STRIDE      = 2,
    parameter int SIGNED      = 0
) (
    input logic          clk,
    input logic          rst,
    pool_engine_if.slave bus
);
    localparam int OW       = (DATAWIDTH - KWIDTH) / STRIDE + 1;
    localparam int OH       = (DATAHEIGHT - KHEIGHT) / STRIDE + 1;
    localparam int K        = KWIDTH * KHEIGHT;
    localparam int LOGK     = $clog2(K);
    localparam int AW       = BITWIDTH + LOGK;
    localparam int AW1      = AW + 1;
    localparam bit K_POW2   = ((K & (K - 1)) == 0);
    localparam int IN_BITS  = BITWIDTH * DATAWIDTH * DATAHEIGHT * DATACHANNEL;
    localparam int OUT_BITS = BITWIDTH * OW * OH * DATACHANNEL;
    localparam int IBW      = $clog2(IN_BITS);
    localparam int OBW      = $clog2(OUT_BITS);
    localparam int KXW      = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;
    localparam int KYW      = (KHEIGHT > 1) ? $clog2(KHEIGHT) : 1;
    localparam int OXW      = (OW > 1) ? $clog2(OW) : 1;
    localparam int OYW      = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW       = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;

    localparam logic [KXW-1:0] KX_LAST = KXW'(KWIDTH - 1);
    localparam logic [KYW-1:0] KY_LAST = KYW'(KHEIGHT - 1);
    localparam logic [OXW-1:0] OX_LAST = OXW'(OW - 1);
    localparam logic [OYW-1:0] OY_LAST = OYW'(OH - 1);
    localparam logic [CW-1:0]  CH_LAST = CW'(DATACHANNEL - 1);
    localparam logic signed [AW1-1:0] K_S   = AW1'(K);
    localparam logic signed [AW1-1:0] S_ONE = AW1'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WRITE} state_t;

    state_t                r_state;
    logic                  r_mode;
    logic                  r_busy;
    logic                  r_valid;
    logic [KXW-1:0]        r_kx;
    logic [KYW-1:0]        r_ky;
    logic [OXW-1:0]        r_ox;
    logic [OYW-1:0]        r_oy;
    logic [CW-1:0]         r_ch;
    logic [AW-1:0]         r_acc;
    logic [OUT_BITS-1:0]   r_result;

    logic [31:0]           w_in_idx;
    logic [31:0]           w_out_idx;
    logic [IBW-1:0]        w_in_bit;
    logic [OBW-1:0]        w_out_bit;
    logic [BITWIDTH-1:0]   w_elem;
    logic [AW-1:0]         w_elem_ext;
    logic                  w_gt;
    logic signed [AW1-1:0] w_sacc;
    logic signed [AW1-1:0] w_sq;
    logic signed [AW1-1:0] w_sr;
    logic [AW-1:0]         w_avg;
    logic [BITWIDTH-1:0]   w_res;
    logic                  w_first;
    logic                  w_win_last;
    logic                  w_frame_last;

    always_comb begin
        w_in_idx  = (32'(r_ch) * DATAHEIGHT + 32'(r_oy) * STRIDE + 32'(r_ky)) * DATAWIDTH
                  + 32'(r_ox) * STRIDE + 32'(r_kx);
        w_out_idx = (32'(r_ch) * OH + 32'(r_oy)) * OW + 32'(r_ox);
        w_in_bit  = IBW'(w_in_idx * BITWIDTH);
        w_out_bit = OBW'(w_out_idx * BITWIDTH);
        w_elem    = bus.data_in[w_in_bit +: BITWIDTH];

        if (SIGNED != 0) begin
            w_elem_ext = AW'($signed(w_elem));
            w_gt       = $signed(w_elem) > $signed(r_acc[BITWIDTH-1:0]);
            w_sacc     = AW1'($signed(r_acc));
        end else begin
            w_elem_ext = AW'(w_elem);
            w_gt       = w_elem > r_acc[BITWIDTH-1:0];
            w_sacc     = AW1'(r_acc);
        end

        // Signed '/' truncates toward zero; step down once to get floor for negative sums.
        w_sq = w_sacc / K_S;
        w_sr = w_sacc % K_S;
        if (w_sacc < 0 && w_sr != 0) begin
            w_sq = w_sq - S_ONE;
        end

        if (K_POW2) begin
            if (SIGNED != 0) begin
                w_avg = AW'($signed(r_acc) >>> LOGK);
            end else begin
                w_avg = r_acc >> LOGK;
            end
        end else begin
            w_avg = AW'(w_sq);
        end

        w_res        = r_mode ? w_avg[BITWIDTH-1:0] : r_acc[BITWIDTH-1:0];
        w_first      = (r_kx == '0) && (r_ky == '0);
        w_win_last   = (r_kx == KX_LAST) && (r_ky == KY_LAST);
        w_frame_last = (r_ox == OX_LAST) && (r_oy == OY_LAST) && (r_ch == CH_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_kx     <= '0;
            r_ky     <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_ch     <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (bus.clken) begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_ch    <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_first) begin
                        r_acc <= w_elem_ext;
                    end else if (r_mode) begin
                        r_acc <= r_acc + w_elem_ext;
                    end else if (w_gt) begin
                        r_acc <= w_elem_ext;
                    end
                    if (r_kx == KX_LAST) begin
                        r_kx <= '0;
                        r_ky <= (r_ky == KY_LAST) ? '0 : r_ky + 1'b1;
                    end else begin
                        r_kx <= r_kx + 1'b1;
                    end
                    if (w_win_last) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_result[w_out_bit +: BITWIDTH] <= w_res;
                    if (r_ox == OX_LAST) begin
                        r_ox <= '0;
                        if (r_oy == OY_LAST) begin
                            r_oy <= '0;
                            r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                        end else begin
                            r_oy <= r_oy + 1'b1;
                        end
                    end else begin
                        r_ox <= r_ox + 1'b1;
                    end
                    if (w_frame_last) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ACC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.result_valid_out = r_valid;
    assign bus.result_out       = r_result;
endmodule

// File: tb/tb_pool_engine.sv
// Drives four pool_engine variants in lockstep and compares them with a window-by-window reference model.
module tb_pool_engine;
    logic clk = 1'b0;
    logic t_rst;
    logic t_clken;
    logic t_start;
    logic t_mode;

    int n_chk  = 0;
    int n_pass = 0;

    // Variant table: A/B 4x4x2 2x2/s2 (unsigned/signed), C 4x4x1 2x2/s1, D 4x4x1 3x2/s1 signed.
    int t_w[4]  = '{4, 4, 4, 4};
    int t_h[4]  = '{4, 4, 4, 4};
    int t_c[4]  = '{2, 2, 1, 1};
    int t_kw[4] = '{2, 2, 2, 3};
    int t_kh[4] = '{2, 2, 2, 2};
    int t_s[4]  = '{2, 2, 1, 1};
    int t_sg[4] = '{0, 1, 0, 1};

    bit [15:0] pool[32];
    int        exp_out[4][9];
    int        nout[4];

    int ramp_max_a[8] = '{5, 7, 13, 15, 15, 13, 7, 5};
    int ramp_avg_a[8] = '{2, 4, 10, 12, 12, 10, 4, 2};
    int ramp_max_c[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    pool_engine_if #(.IN_BITS(512), .OUT_BITS(128)) ifa ();
    pool_engine_if #(.IN_BITS(512), .OUT_BITS(128)) ifb ();
    pool_engine_if #(.IN_BITS(256), .OUT_BITS(144)) ifc ();
    pool_engine_if #(.IN_BITS(256), .OUT_BITS(96))  ifd ();

    assign ifa.clken = t_clken;  assign ifa.start = t_start;  assign ifa.mode = t_mode;
    assign ifb.clken = t_clken;  assign ifb.start = t_start;  assign ifb.mode = t_mode;
    assign ifc.clken = t_clken;  assign ifc.start = t_start;  assign ifc.mode = t_mode;
    assign ifd.clken = t_clken;  assign ifd.start = t_start;  assign ifd.mode = t_mode;

    pool_engine #(.BITWIDTH(16), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(2),
                  .KWIDTH(2), .KHEIGHT(2), .STRIDE(2), .SIGNED(0))
        u_dut_a (.clk(clk), .rst(t_rst), .bus(ifa));
    pool_engine #(.BITWIDTH(16), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(2),
                  .KWIDTH(2), .KHEIGHT(2), .STRIDE(2), .SIGNED(1))
        u_dut_b (.clk(clk), .rst(t_rst), .bus(ifb));
    pool_engine #(.BITWIDTH(16), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(1),
                  .KWIDTH(2), .KHEIGHT(2), .STRIDE(1), .SIGNED(0))
        u_dut_c (.clk(clk), .rst(t_rst), .bus(ifc));
    pool_engine #(.BITWIDTH(16), .DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(1),
                  .KWIDTH(3), .KHEIGHT(2), .STRIDE(1), .SIGNED(1))
        u_dut_d (.clk(clk), .rst(t_rst), .bus(ifd));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] get_out(input int d, input int s);
        case (d)
            0:       return 16'(ifa.result_out >> (s * 16));
            1:       return 16'(ifb.result_out >> (s * 16));
            2:       return 16'(ifc.result_out >> (s * 16));
            default: return 16'(ifd.result_out >> (s * 16));
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return ifa.busy;
            1:       return ifb.busy;
            2:       return ifc.busy;
            default: return ifd.busy;
        endcase
    endfunction

    function automatic logic get_valid(input int d);
        case (d)
            0:       return ifa.result_valid_out;
            1:       return ifb.result_valid_out;
            2:       return ifc.result_valid_out;
            default: return ifd.result_valid_out;
        endcase
    endfunction

    function automatic logic get_res_nz(input int d);
        case (d)
            0:       return |ifa.result_out;
            1:       return |ifb.result_out;
            2:       return |ifc.result_out;
            default: return |ifd.result_out;
        endcase
    endfunction

    // Reference: straight nested loops over windows, values interpreted per the variant's signedness.
    function automatic void model(input int d, input bit md);
        int ow, oh, k, acc, v, q, idx;
        bit first;
        ow = (t_w[d] - t_kw[d]) / t_s[d] + 1;
        oh = (t_h[d] - t_kh[d]) / t_s[d] + 1;
        k  = t_kw[d] * t_kh[d];
        nout[d] = ow * oh * t_c[d];
        for (int c = 0; c < t_c[d]; c++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    acc = 0;
                    first = 1'b1;
                    for (int ky = 0; ky < t_kh[d]; ky++)
                        for (int kx = 0; kx < t_kw[d]; kx++) begin
                            idx = c * t_h[d] * t_w[d] + (oy * t_s[d] + ky) * t_w[d] + ox * t_s[d] + kx;
                            v = (t_sg[d] != 0) ? int'($signed(pool[idx])) : int'(pool[idx]);
                            if (md) acc += v;
                            else if (first || v > acc) acc = v;
                            first = 1'b0;
                        end
                    if (md) begin
                        q = acc / k;
                        if (acc % k != 0 && acc < 0) q--;
                        acc = q;
                    end
                    exp_out[d][(c * oh + oy) * ow + ox] = acc & 32'hFFFF;
                end
    endfunction

    task automatic set_data();
        ifa.data_in = '0;
        ifb.data_in = '0;
        ifc.data_in = '0;
        ifd.data_in = '0;
        for (int i = 0; i < 32; i++) begin
            ifa.data_in = ifa.data_in | (512'(pool[i]) << (i * 16));
            ifb.data_in = ifb.data_in | (512'(pool[i]) << (i * 16));
        end
        for (int i = 0; i < 16; i++) begin
            ifc.data_in = ifc.data_in | (256'(pool[i]) << (i * 16));
            ifd.data_in = ifd.data_in | (256'(pool[i]) << (i * 16));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) pool[i] = 16'($urandom);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) pool[i] = (i < 16) ? 16'(i) : 16'(31 - i);
    endtask

    task automatic fill_signed();
        for (int i = 0; i < 32; i++)
            pool[i] = ((i % 2 == 1) && ((i / 4) % 2 == 1)) ? 16'hFFFF : 16'hFFFD;
    endtask

    // One frame on all variants; optional clken stall, stray start while busy, back-to-back restart on A/B.
    task automatic run_frame(input bit md, input int stall_at, input int start_again, input bit b2b);
        int first[4];
        int highs[4];
        int lat[4];
        int a2;
        int extra;
        extra = (stall_at > 0) ? 5 : 0;
        a2 = -1;
        for (int d = 0; d < 4; d++) begin
            model(d, md);
            first[d] = -1;
            highs[d] = 0;
            lat[d]   = nout[d] * (t_kw[d] * t_kh[d] + 1);
        end
        set_data();
        @(negedge clk);
        t_mode  = md;
        t_start = 1'b1;
        t_clken = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) chk($sformatf("busy_e0_d%0d", d), 32'(get_busy(d)), 32'd1);
        t_mode  = ~md;
        t_start = (start_again == 1);
        t_clken = !(stall_at > 0 && 1 >= stall_at && 1 < stall_at + 5);
        for (int e = 1; e <= 90; e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (get_valid(d)) begin
                    if (b2b && d < 2 && first[d] >= 0 && e > first[d] + 1) begin
                        if (d == 0 && a2 < 0) a2 = e;
                    end else begin
                        highs[d]++;
                        if (first[d] < 0) begin
                            first[d] = e;
                            chk($sformatf("busy_at_valid_d%0d", d), 32'(get_busy(d)), 32'd0);
                        end
                    end
                end
            end
            if (b2b && first[0] >= 0 && e == first[0] + 1)
                chk("b2b_busy_a", 32'(get_busy(0)), 32'd1);
            t_clken = !(stall_at > 0 && e + 1 >= stall_at && e + 1 < stall_at + 5);
            t_start = (e + 1 == start_again) || (b2b && first[0] == e);
            t_mode  = (b2b && first[0] == e) ? md : ~md;
        end
        t_start = 1'b0;
        t_clken = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("latency_d%0d", d), 32'(first[d]), 32'(lat[d] + extra));
            chk($sformatf("valid_width_d%0d", d), 32'(highs[d]), 32'd1);
            for (int s = 0; s < nout[d]; s++)
                chk($sformatf("result_d%0d_s%0d", d, s), 32'(get_out(d, s)), 32'(exp_out[d][s]));
        end
        if (b2b) chk("b2b_latency_a", 32'(a2), 32'(first[0] + 1 + lat[0]));
    endtask

    task automatic reset_mid_frame();
        set_data();
        @(negedge clk);
        t_mode  = 1'b0;
        t_start = 1'b1;
        @(posedge clk);
        #1;
        t_start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        t_rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_busy_d%0d", d), 32'(get_busy(d)), 32'd0);
            chk($sformatf("rst_valid_d%0d", d), 32'(get_valid(d)), 32'd0);
            chk($sformatf("rst_result_d%0d", d), 32'(get_res_nz(d)), 32'd0);
        end
        @(negedge clk);
        t_rst = 1'b0;
    endtask

    initial begin
        t_rst   = 1'b1;
        t_clken = 1'b1;
        t_start = 1'b0;
        t_mode  = 1'b0;
        for (int i = 0; i < 32; i++) pool[i] = '0;
        set_data();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_busy_d%0d", d), 32'(get_busy(d)), 32'd0);
            chk($sformatf("reset_valid_d%0d", d), 32'(get_valid(d)), 32'd0);
            chk($sformatf("reset_result_d%0d", d), 32'(get_res_nz(d)), 32'd0);
        end
        @(negedge clk);
        t_rst = 1'b0;

        fill_ramp();
        run_frame(1'b0, 0, 0, 1'b0);
        for (int s = 0; s < 8; s++) chk($sformatf("ramp_max_a_s%0d", s), 32'(get_out(0, s)), 32'(ramp_max_a[s]));
        for (int s = 0; s < 9; s++) chk($sformatf("ramp_max_c_s%0d", s), 32'(get_out(2, s)), 32'(ramp_max_c[s]));
        run_frame(1'b1, 0, 0, 1'b0);
        for (int s = 0; s < 8; s++) chk($sformatf("ramp_avg_a_s%0d", s), 32'(get_out(0, s)), 32'(ramp_avg_a[s]));

        fill_signed();
        run_frame(1'b0, 0, 0, 1'b0);
        for (int s = 0; s < 8; s++) chk($sformatf("neg_max_b_s%0d", s), 32'(get_out(1, s)), 32'h0000FFFF);
        run_frame(1'b1, 0, 0, 1'b0);
        for (int s = 0; s < 8; s++) chk($sformatf("neg_avg_b_s%0d", s), 32'(get_out(1, s)), 32'h0000FFFD);

        fill_random();
        run_frame(1'($urandom), 12, 10, 1'b0);
        fill_random();
        run_frame(1'($urandom), 0, 0, 1'b1);

        fill_random();
        reset_mid_frame();
        fill_random();
        run_frame(1'b0, 0, 0, 1'b0);

        repeat (12) begin
            fill_random();
            run_frame(1'($urandom), 0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
